// File: rtl/uart_trx.sv
// UART transceiver: registered TX serializer, synchronized RX deserializer, FWFT RX FIFO.
// Optional parity on both directions when UART_PARITY_EN is defined.
module uart_trx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          CLK_100MHz,
  input  logic                          Reset,
  input  logic [DATA_BITS-1:0]          TxData,
  input  logic                          TxValid,
  output logic                          TxReady,
  output logic                          Tx,
  input  logic                          Rx,
  output logic [DATA_BITS-1:0]          RxData,
  output logic                          RxValid,
  input  logic                          RxReady,
  output logic [$clog2(FIFO_DEPTH):0]   RxCount,
  output logic                          RxOverrun,
  output logic                          FrameError,
  output logic                          ParityError
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    DBIT_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SBIT_LAST = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8 || CLKS_PER_BIT < 4 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 || FIFO_DEPTH > 256 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
    $error("uart_trx: illegal parameter value");
  end

`ifdef UART_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // ---------------- TX ----------------
  state_t               tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_q, tx_d;
  logic                 tx_last;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  assign tx_last = (tx_cnt_q == CNT_LAST);
  assign TxReady = (tx_state_q == S_IDLE);
  assign Tx      = tx_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    if (tx_state_q != S_IDLE) tx_cnt_d = tx_last ? '0 : tx_cnt_q + 1'b1;
    case (tx_state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (TxValid) begin
          tx_state_d = S_START;
          tx_d       = 1'b0;
          tx_shift_d = TxData;
          tx_cnt_d   = '0;
`ifdef UART_PARITY_EN
          tx_par_d   = (^TxData) ^ PAR_ODD;
`endif
        end
      end
      S_START: if (tx_last) begin
        tx_state_d = S_DATA;
        tx_d       = tx_shift_q[0];
        tx_bit_d   = '0;
      end
      S_DATA: if (tx_last) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == DBIT_LAST) begin
`ifdef UART_PARITY_EN
          tx_state_d = S_PARITY;
          tx_d       = tx_par_q;
`else
          tx_state_d = S_STOP;
          tx_d       = 1'b1;
          tx_bit_d   = '0;
`endif
        end else begin
          tx_bit_d = tx_bit_q + 4'd1;
          tx_d     = tx_shift_q[1];
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (tx_last) begin
        tx_state_d = S_STOP;
        tx_d       = 1'b1;
        tx_bit_d   = '0;
      end
`endif
      S_STOP: if (tx_last) begin
        // Ready rises right after the last stop period, so a waiting frame starts one cycle later.
        if (tx_bit_q == SBIT_LAST) tx_state_d = S_IDLE;
        else                       tx_bit_d   = tx_bit_q + 4'd1;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_100MHz or posedge Reset) begin
    if (Reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // ---------------- RX ----------------
  state_t               rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [1:0]           sync_q;
  logic                 rx_s, rx_prev_q, rx_last;
  logic                 rx_push_q, rx_push_d, fe_q, fe_d;
`ifdef UART_PARITY_EN
  logic                 rx_par_q, rx_par_d, pe_q, pe_d, rx_par_bad;
  assign rx_par_bad  = (^rx_shift_q) ^ rx_par_q ^ PAR_ODD;
  assign ParityError = pe_q;
`else
  assign ParityError = 1'b0;
`endif

  assign rx_s       = sync_q[1];
  assign rx_last    = (rx_cnt_q == CNT_LAST);
  assign FrameError = fe_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push_d  = 1'b0;
    fe_d       = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_d   = rx_par_q;
    pe_d       = 1'b0;
`endif
    if (rx_state_q != S_IDLE) rx_cnt_d = rx_last ? '0 : rx_cnt_q + 1'b1;
    case (rx_state_q)
      // Edge rather than level detect: after a framing error the line must go high first.
      S_IDLE: if (rx_prev_q && !rx_s) begin
        rx_state_d = S_START;
        rx_cnt_d   = '0;
      end
      S_START: if (rx_cnt_q == CNT_HALF) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_last) begin
        rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == DBIT_LAST) begin
`ifdef UART_PARITY_EN
          rx_state_d = S_PARITY;
`else
          rx_state_d = S_STOP;
`endif
        end else begin
          rx_bit_d = rx_bit_q + 4'd1;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (rx_last) begin
        rx_par_d   = rx_s;
        rx_state_d = S_STOP;
      end
`endif
      S_STOP: if (rx_last) begin
        rx_state_d = S_IDLE;
        fe_d       = !rx_s;
`ifdef UART_PARITY_EN
        pe_d       = rx_par_bad;
        rx_push_d  = rx_s && !rx_par_bad;
`else
        rx_push_d  = rx_s;
`endif
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_100MHz or posedge Reset) begin
    if (Reset) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_push_q  <= 1'b0;
      fe_q       <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q   <= 1'b0;
      pe_q       <= 1'b0;
`endif
    end else begin
      sync_q     <= {sync_q[0], Rx};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_push_q  <= rx_push_d;
      fe_q       <= fe_d;
`ifdef UART_PARITY_EN
      rx_par_q   <= rx_par_d;
      pe_q       <= pe_d;
`endif
    end
  end

  // ---------------- RX FIFO (first-word fall-through) ----------------
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          cnt_q;
  logic                 full, pop, do_push, ovr_q;

  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop     = RxReady && (cnt_q != '0);
  assign do_push = rx_push_q && (!full || pop);

  assign RxValid   = (cnt_q != '0);
  assign RxData    = RxValid ? mem_q[rd_q] : '0;
  assign RxCount   = cnt_q;
  assign RxOverrun = ovr_q;

  // rx_shift_q still holds the received byte the cycle after the stop sample.
  always_ff @(posedge CLK_100MHz) begin
    if (do_push) mem_q[wr_q] <= rx_shift_q;
  end

  always_ff @(posedge CLK_100MHz or posedge Reset) begin
    if (Reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      case ({do_push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      ovr_q <= rx_push_q && full && !pop;
    end
  end

endmodule

// File: tb/tb_uart_trx.sv
// Directed + randomized bench for uart_trx (CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4).
module tb_uart_trx;
  localparam int CPB = 4;
  localparam int FD  = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0, tx_ready, tx;
  logic       rx_drv = 1'b1, loop = 1'b0, rx_line;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready = 1'b0;
  logic [2:0] rx_count;
  logic       ovr, fe, pe;

  int n_cmp = 0, n_bad = 0;
  int fe_n = 0, pe_n = 0, ovr_n = 0, wide_n = 0;
  logic fe_p = 1'b0, pe_p = 1'b0, ovr_p = 1'b0;

  assign rx_line = loop ? tx : rx_drv;
  always #5 clk = ~clk;

  uart_trx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(FD), .PARITY_ODD(0)) dut (
    .CLK_100MHz(clk), .Reset(rst),
    .TxData(tx_data), .TxValid(tx_valid), .TxReady(tx_ready), .Tx(tx),
    .Rx(rx_line), .RxData(rx_data), .RxValid(rx_valid), .RxReady(rx_ready), .RxCount(rx_count),
    .RxOverrun(ovr), .FrameError(fe), .ParityError(pe)
  );

  // Pulse counters; any pulse lasting two cycles is recorded as wide.
  always @(negedge clk) begin
    if (!rst) begin
      fe_n  += int'(fe);
      pe_n  += int'(pe);
      ovr_n += int'(ovr);
      if ((fe && fe_p) || (pe && pe_p) || (ovr && ovr_p)) wide_n++;
    end
    fe_p = fe; pe_p = pe; ovr_p = ovr;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required: bench completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Line level of frame bit i: start, data LSB first, (even parity), stop.
  function automatic logic exp_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (i == 9 && NB == 11) return ^d;
    return 1'b1;
  endfunction

  task automatic tx_send_check(input logic [7:0] d);
    int k = 0;
    while (!tx_ready && k < 200) begin @(negedge clk); k++; end
    chk("tx_ready_before", tx_ready, 1);
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("tx_ready_drop", tx_ready, 0);
    for (int n = 0; n < NB*CPB; n++) begin
      if (n > 0) @(negedge clk);
      chk($sformatf("tx_bit%0d_of_%02h", n / CPB, d), tx, exp_bit(d, n / CPB));
    end
    chk("tx_ready_in_last_stop", tx_ready, 0);
    @(negedge clk);
    chk("tx_ready_rise", tx_ready, 1);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop, input logic par);
    for (int i = 0; i < NB; i++) begin
      logic b;
      if (i == 0)                  b = 1'b0;
      else if (i <= 8)             b = d[i-1];
      else if (i == 9 && NB == 11) b = par;
      else                         b = stop;
      rx_drv = b;
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_rx(input int lim);
    int k = 0;
    while (!rx_valid && k < lim) begin @(negedge clk); k++; end
    chk("rx_valid_wait", rx_valid, 1);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, rx_data, exp);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] d;
    bit         bad;
    int         fe_e, ovr_e, base;

    // Reset state
    cyc(3);
    chk("rst_tx", tx, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_pulses", {ovr, fe, pe}, 0);
    rst = 1'b0;
    cyc(3);

    // Fixed TX waveform for A5
    tx_send_check(8'hA5);

    // Loopback 3C
    loop = 1'b1;
    cyc(2);
    tx_send_check(8'h3C);
    wait_rx(20);
    chk("loop_data", rx_data, 8'h3C);
    chk("loop_count", rx_count, 1);
    pop_chk("loop_pop", 8'h3C);
    chk("loop_empty", rx_valid, 0);
    loop = 1'b0;
    cyc(3);

    // One-cycle glitch must not produce anything; RX still usable afterwards
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    cyc(20);
    chk("glitch_count", rx_count, 0);
    chk("glitch_fe", fe_n, 0);
    chk("glitch_valid", rx_valid, 0);
    d = 8'h96;
    rx_frame(d, 1'b1, ^d);
    cyc(4);
    chk("post_glitch_count", rx_count, 1);
    pop_chk("post_glitch_data", 8'h96);

    // Framing error
    d = 8'h55;
    rx_frame(d, 1'b0, ^d);
    cyc(4);
    chk("fe_pulse", fe_n, 1);
    chk("fe_count", rx_count, 0);
    chk("fe_valid", rx_valid, 0);

    // Overrun on fifth frame
    base = ovr_n;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      rx_frame(d, 1'b1, ^d);
      cyc(3);
      if (i == 4) chk("ovr_none_at_4", ovr_n - base, 0);
    end
    chk("ovr_count", rx_count, 4);
    chk("ovr_pulse", ovr_n - base, 1);

    // Push and pop in the same cycle while full: no overrun, count unchanged
    d = 8'hE7;
    rx_frame(d, 1'b1, ^d);
    @(negedge clk);
    pop_chk("pp_head", 8'h01);
    cyc(3);
    chk("pp_count", rx_count, 4);
    chk("pp_no_ovr", ovr_n - base, 1);
    pop_chk("pop_02", 8'h02);
    pop_chk("pop_03", 8'h03);
    pop_chk("pop_04", 8'h04);
    pop_chk("pop_E7", 8'hE7);
    chk("drained", rx_valid, 0);

`ifdef UART_PARITY_EN
    base = pe_n;
    rx_frame(8'h07, 1'b1, 1'b0);
    cyc(4);
    chk("pe_pulse", pe_n - base, 1);
    chk("pe_count", rx_count, 0);
    rx_frame(8'h07, 1'b1, 1'b1);
    cyc(4);
    chk("par_ok_count", rx_count, 1);
    pop_chk("par_ok_data", 8'h07);
`endif

    // Random concurrent TX/RX against a queue model
    fe_e = fe_n; ovr_e = ovr_n;
    for (int it = 0; it < 12; it++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      fork
        tx_send_check(8'($urandom));
        rx_frame(d, !bad, ^d);
      join
      cyc(3);
      if (bad)                fe_e++;
      else if (q.size() == FD) ovr_e++;
      else                    q.push_back(d);
      chk("rnd_count", rx_count, q.size());
      chk("rnd_fe", fe_n, fe_e);
      chk("rnd_ovr", ovr_n, ovr_e);
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        pop_chk("rnd_pop", q[0]);
        void'(q.pop_front());
      end
    end
    while (q.size() > 0) begin
      pop_chk("rnd_drain", q[0]);
      void'(q.pop_front());
    end
    chk("rnd_empty", rx_valid, 0);

    // Reset mid-frame on both directions
    d = 8'hC3;
    rx_frame(d, 1'b1, ^d);
    cyc(3);
    chk("pre_rst_count", rx_count, 1);
    tx_data = 8'h00; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    cyc(6);
    chk("pre_rst_tx_low", tx, 0);
    rx_drv = 1'b0;
    cyc(6);
    base = fe_n;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_ready", tx_ready, 1);
    chk("mid_rst_count", rx_count, 0);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rx_data, 0);
    rx_drv = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(50);
    chk("post_rst_empty", rx_count, 0);
    chk("post_rst_fe", fe_n - base, 0);
    chk("post_rst_tx_idle", tx, 1);

    chk("pulse_width", wide_n, 0);
`ifndef UART_PARITY_EN
    chk("no_parity_err", pe_n, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
